writeback_sequencer: RTL and testbench



---
 rtl/writeback_sequencer_pkg.sv | 21 ++
 rtl/writeback_sequencer_if.sv | 36 +++
 rtl/writeback_sequencer_result_mux.sv | 31 +++
 rtl/writeback_sequencer.sv | 126 ++++++++++++
 tb/tb_writeback_sequencer.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/writeback_sequencer_pkg.sv
// rtl/writeback_sequencer_pkg.sv - shared encodings and constants for the writeback sequencer
package writeback_sequencer_pkg;

    // Result source select carried with each retiring instruction
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC1  = 2'b10,
        WB_IMM  = 2'b11
    } wb_sel_e;

    // Fixed bank locations of the two flag registers
    localparam int ZERO_FLAG_ADDR   = 0;
    localparam int BRANCH_FLAG_ADDR = 1;

    // Bit positions inside the pending-write mask; issue order is lowest first
    localparam int PEND_RD = 0;
    localparam int PEND_Z  = 1;
    localparam int PEND_BR = 2;

endpackage

// File: rtl/writeback_sequencer_if.sv
// rtl/writeback_sequencer_if.sv - retire handshake and register-bank write bus
interface writeback_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] pc_plus1;
    logic [DATA_WIDTH-1:0] imm;
    logic [1:0]            wb_sel;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_wr;
    logic                  z_upd;
    logic                  br_upd;
    logic                  br_taken;
    logic                  reg_wr;
    logic [ADDR_WIDTH-1:0] address_wr;
    logic [DATA_WIDTH-1:0] data_wr;
    logic [31:0]           retire_cnt;

    // Upstream pipeline / bench side
    modport master (
        output in_valid, alu_result, mem_data, pc_plus1, imm, wb_sel,
               rd_addr, rd_wr, z_upd, br_upd, br_taken,
        input  in_ready, reg_wr, address_wr, data_wr, retire_cnt
    );

    // Sequencer side
    modport slave (
        input  in_valid, alu_result, mem_data, pc_plus1, imm, wb_sel,
               rd_addr, rd_wr, z_upd, br_upd, br_taken,
        output in_ready, reg_wr, address_wr, data_wr, retire_cnt
    );
endinterface

// File: rtl/writeback_sequencer_result_mux.sv
// rtl/writeback_sequencer_result_mux.sv - result source select and ALU zero detect
module writeback_sequencer_result_mux
    import writeback_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            wb_sel,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] pc_plus1,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic [DATA_WIDTH-1:0] sel_value,
    output logic                  alu_zero
);

    // 4:1 select of the value destined for rd
    always_comb begin
        sel_value = alu_result;
        case (wb_sel_e'(wb_sel))
            WB_ALU:  sel_value = alu_result;
            WB_MEM:  sel_value = mem_data;
            WB_PC1:  sel_value = pc_plus1;
            WB_IMM:  sel_value = imm;
            default: sel_value = alu_result;
        endcase
    end

    // Zero flag always reflects the ALU, whatever feeds rd
    assign alu_zero = (alu_result == '0);

endmodule

// File: rtl/writeback_sequencer.sv
// rtl/writeback_sequencer.sv - serialises rd/zero/branch writes into the single bank port
module writeback_sequencer
    import writeback_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 4,
    parameter int ZERO_FLAG_ADDR   = writeback_sequencer_pkg::ZERO_FLAG_ADDR,
    parameter int BRANCH_FLAG_ADDR = writeback_sequencer_pkg::BRANCH_FLAG_ADDR
) (
    input logic                  clk,
    input logic                  rst,
    writeback_sequencer_if.slave bus
);

    logic [2:0]            pend;
    logic [2:0]            new_bits;
    logic [2:0]            cur;
    logic [2:0]            issue_bit;
    logic [2:0]            rest;
    logic [2:0]            next_pend;
    logic [DATA_WIDTH-1:0] sel_value;
    logic [DATA_WIDTH-1:0] held_value;
    logic [DATA_WIDTH-1:0] c_value;
    logic [DATA_WIDTH-1:0] iss_data;
    logic [ADDR_WIDTH-1:0] held_rd;
    logic [ADDR_WIDTH-1:0] c_rd;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic                  sel_zero;
    logic                  held_zero;
    logic                  held_br;
    logic                  c_zero;
    logic                  c_br;
    logic                  in_ready;
    logic                  accept;
    logic                  last_issue;
    logic [1:0]            retire_inc;
    logic                  reg_wr_q;
    logic [ADDR_WIDTH-1:0] address_wr_q;
    logic [DATA_WIDTH-1:0] data_wr_q;
    logic [31:0]           retire_cnt_q;

    writeback_sequencer_result_mux #(.DATA_WIDTH(DATA_WIDTH)) u_result_mux (
        .wb_sel     (bus.wb_sel),
        .alu_result (bus.alu_result),
        .mem_data   (bus.mem_data),
        .pc_plus1   (bus.pc_plus1),
        .imm        (bus.imm),
        .sel_value  (sel_value),
        .alu_zero   (sel_zero)
    );

    // Ready while at most one write remains, since that write drains this edge
    assign in_ready = !((pend[0] & pend[1]) | (pend[0] & pend[2]) | (pend[1] & pend[2]));
    assign accept   = bus.in_valid & in_ready;
    assign new_bits = {bus.br_upd, bus.z_upd, bus.rd_wr};

    // Pick the write to issue: held work first, else the lowest bit of a fresh accept
    always_comb begin
        cur       = '0;
        c_value   = held_value;
        c_rd      = held_rd;
        c_zero    = held_zero;
        c_br      = held_br;
        if (pend != '0) begin
            cur = pend;
        end else if (accept) begin
            cur     = new_bits;
            c_value = sel_value;
            c_rd    = bus.rd_addr;
            c_zero  = sel_zero;
            c_br    = bus.br_taken;
        end
        issue_bit  = cur & (~cur + 3'd1);
        rest       = cur & ~issue_bit;
        next_pend  = (pend != '0 && accept) ? new_bits : rest;
        last_issue = (issue_bit != '0) && (rest == '0);
        retire_inc = {1'b0, last_issue} + {1'b0, accept && (new_bits == '0)};
        iss_addr   = c_rd;
        iss_data   = c_value;
        if (issue_bit[PEND_Z]) begin
            iss_addr = ADDR_WIDTH'(ZERO_FLAG_ADDR);
            iss_data = {{(DATA_WIDTH-1){1'b0}}, c_zero};
        end else if (issue_bit[PEND_BR]) begin
            iss_addr = ADDR_WIDTH'(BRANCH_FLAG_ADDR);
            iss_data = {{(DATA_WIDTH-1){1'b0}}, c_br};
        end
    end

    // Pending mask, operand capture, registered bank write and retire count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend         <= '0;
            held_value   <= '0;
            held_rd      <= '0;
            held_zero    <= 1'b0;
            held_br      <= 1'b0;
            reg_wr_q     <= 1'b0;
            address_wr_q <= '0;
            data_wr_q    <= '0;
            retire_cnt_q <= '0;
        end else begin
            pend <= next_pend;
            if (accept) begin
                held_value <= sel_value;
                held_rd    <= bus.rd_addr;
                held_zero  <= sel_zero;
                held_br    <= bus.br_taken;
            end
            if (issue_bit != '0) begin
                reg_wr_q     <= 1'b1;
                address_wr_q <= iss_addr;
                data_wr_q    <= iss_data;
            end else begin
                reg_wr_q     <= 1'b0;
            end
            retire_cnt_q <= retire_cnt_q + 32'(retire_inc);
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.reg_wr     = reg_wr_q;
    assign bus.address_wr = address_wr_q;
    assign bus.data_wr    = data_wr_q;
    assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_writeback_sequencer.sv
// tb/tb_writeback_sequencer.sv - directed self-checking bench for writeback_sequencer
module tb_writeback_sequencer;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    writeback_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

    writeback_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc, input logic [31:0] im,
                         input logic [3:0] rd, input logic w, input logic z, input logic b,
                         input logic bt);
        bus.in_valid   = v;
        bus.wb_sel     = sel;
        bus.alu_result = alu;
        bus.mem_data   = mem;
        bus.pc_plus1   = pc;
        bus.imm        = im;
        bus.rd_addr    = rd;
        bus.rd_wr      = w;
        bus.z_upd      = z;
        bus.br_upd     = b;
        bus.br_taken   = bt;
    endtask

    task automatic chk_wr(input string tag, input logic wr, input logic [3:0] a, input logic [31:0] d);
        chk({tag, ".reg_wr"}, 32'(bus.reg_wr), 32'(wr));
        chk({tag, ".addr"}, 32'(bus.address_wr), 32'(a));
        chk({tag, ".data"}, bus.data_wr, d);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk_wr("reset", 0, 0, 0);
        chk("reset.retire", bus.retire_cnt, 0);
        chk("reset.ready", 32'(bus.in_ready), 1);
        rst = 1'b0;
        step();

        // ALU op: single rd write
        drive(1, 2'b00, 32'h5, 32'h11, 32'h22, 32'h33, 4'd7, 1, 0, 0, 0);
        step();
        chk_wr("alu.w", 1, 7, 32'h5);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk_wr("alu.idle", 0, 7, 32'h5);
        chk("alu.retire", bus.retire_cnt, 1);

        // Compare: rd, zero flag, branch flag
        drive(1, 2'b00, 32'h0, 0, 0, 0, 4'd3, 1, 1, 1, 1);
        step();
        chk_wr("cmp.rd", 1, 3, 32'h0);
        chk("cmp.ready1", 32'(bus.in_ready), 0);
        drive(0, 2'b00, 32'h9, 0, 0, 0, 4'd8, 0, 0, 0, 0);
        step();
        chk_wr("cmp.z", 1, 0, 32'h1);
        chk("cmp.ready2", 32'(bus.in_ready), 1);
        step();
        chk_wr("cmp.br", 1, 1, 32'h1);
        chk("cmp.retire", bus.retire_cnt, 2);
        step();
        chk("cmp.idle", 32'(bus.reg_wr), 0);

        // Back-to-back rd-only instructions using every result source
        drive(1, 2'b00, 32'h40, 32'h1, 32'h2, 32'h3, 4'd4, 1, 0, 0, 0);
        step();
        chk_wr("b2b.4", 1, 4, 32'h40);
        chk("b2b.ready", 32'(bus.in_ready), 1);
        drive(1, 2'b10, 32'h1, 32'h2, 32'h50, 32'h3, 4'd5, 1, 0, 0, 0);
        step();
        chk_wr("b2b.5", 1, 5, 32'h50);
        drive(1, 2'b11, 32'h1, 32'h2, 32'h3, 32'h60, 4'd6, 1, 0, 0, 0);
        step();
        chk_wr("b2b.6", 1, 6, 32'h60);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("b2b.retire", bus.retire_cnt, 5);
        step();
        chk("b2b.idle", 32'(bus.reg_wr), 0);

        // Overlap: rd+z instruction, then a load accepted while the flag write issues
        drive(1, 2'b00, 32'h7, 0, 0, 0, 4'd2, 1, 1, 0, 0);
        step();
        chk_wr("ovl.rd", 1, 2, 32'h7);
        chk("ovl.ready", 32'(bus.in_ready), 1);
        drive(1, 2'b01, 32'h0, 32'hDEADBEEF, 32'h4, 32'h5, 4'd9, 1, 0, 0, 0);
        step();
        chk_wr("ovl.z", 1, 0, 32'h0);
        chk("ovl.retire1", bus.retire_cnt, 6);
        drive(0, 2'b00, 32'h0, 32'h12345678, 0, 0, 4'd10, 1, 0, 0, 0);
        step();
        chk_wr("ovl.ld", 1, 9, 32'hDEADBEEF);
        chk("ovl.retire2", bus.retire_cnt, 7);
        step();
        chk("ovl.idle", 32'(bus.reg_wr), 0);

        // Zero-write instruction while idle
        drive(1, 2'b00, 32'h3, 0, 0, 0, 4'd12, 0, 0, 0, 1);
        step();
        chk_wr("zw", 0, 9, 32'hDEADBEEF);
        chk("zw.retire", bus.retire_cnt, 8);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // rd aliases the zero-flag register: rd write then flag write
        drive(1, 2'b00, 32'h5, 0, 0, 0, 4'd0, 1, 1, 0, 0);
        step();
        chk_wr("alias.rd", 1, 0, 32'h5);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk_wr("alias.z", 1, 0, 32'h0);
        chk("alias.retire", bus.retire_cnt, 9);
        step();

        // Reset between the zero and branch writes drops the rest
        drive(1, 2'b00, 32'h0, 0, 0, 0, 4'd3, 1, 1, 1, 1);
        step();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk_wr("rst.z", 1, 0, 32'h1);
        rst = 1'b1;
        #1;
        chk_wr("rst.now", 0, 0, 0);
        chk("rst.retire", bus.retire_cnt, 0);
        chk("rst.ready", 32'(bus.in_ready), 1);
        rst = 1'b0;
        step();
        chk("rst.nobr1", 32'(bus.reg_wr), 0);
        step();
        chk("rst.nobr2", 32'(bus.reg_wr), 0);
        chk("rst.retire2", bus.retire_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
